// File: rtl/fifo_ep_usr_rd.sv
// User-side read endpoint: streams master-written ring words with byte enables and commits the consumed read pointer.
// Read-to-valid latency 2 clocks, 1 word/clock sustained; out_ready low stops reads once the skid and the in-flight word fill 2 slots.
module fifo_ep_usr_rd #(
   parameter int               T_MSZ       = 13,
   parameter int               EP_MSZ      = 11,
   parameter logic [T_MSZ-1:0] EP_BASE_ADR = '0,
   parameter int               COMMIT_LEN  = 16
) (
   input  logic              fifoClk,
   input  logic              fifoRstn,
   input  logic [EP_MSZ:0]   ep_wr_ptr,
   input  logic [3:0]        ep_last_be,
   input  logic              i_flush,
   output logic              ram_rd_en,
   output logic [T_MSZ-1:0]  ram_rd_adr,
   input  logic [31:0]       ram_rd_data,
   output logic [31:0]       out_data,
   output logic [3:0]        out_be,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EP_MSZ:0]   c_rd_ptr,
   output logic              u_rd_ptr
);

   localparam int              PW      = EP_MSZ + 1;
   localparam logic [EP_MSZ:0] CMT_LEN = PW'(COMMIT_LEN);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FLUSH} state_t;

   state_t          state;
   logic [EP_MSZ:0] fetch_ptr, cons_ptr, cmt_ptr, cons_nxt, pend;
   logic [31:0]     skid_dat [2];
   logic [3:0]      skid_be  [2];
   logic [1:0]      skid_cnt, cnt_after_pop, skid_cnt_nxt, occ;
   logic            inflight, pop, push, ring_empty, commit;
   logic [3:0]      inflight_be, be_tag;

   assign ring_empty    = (fetch_ptr == ep_wr_ptr);
   assign out_valid     = (skid_cnt != 2'd0);
   assign out_data      = skid_dat[0];
   assign out_be        = skid_be[0];
   assign pop           = out_valid & out_ready;
   assign push          = inflight & ~i_flush;
   assign cons_nxt      = cons_ptr + PW'(pop);
   assign cnt_after_pop = skid_cnt - {1'b0, pop};
   assign occ           = cnt_after_pop + {1'b0, inflight};

   // Occupancy counts the head leaving this cycle so a streaming consumer sees no bubbles.
   assign ram_rd_en  = fifoRstn & ~ring_empty & ~i_flush & (state != S_HOLD) & (occ < 2'd2);
   assign ram_rd_adr = ram_rd_en ? EP_BASE_ADR + T_MSZ'(fetch_ptr[EP_MSZ-1:0]) : '0;
   assign be_tag     = ((fetch_ptr + PW'(1)) == ep_wr_ptr) ? ep_last_be : 4'hF;

   assign skid_cnt_nxt = i_flush ? 2'd0 : cnt_after_pop + {1'b0, push};
   assign pend         = cons_nxt - cmt_ptr;
   assign commit       = (pend != '0) &
                         ((pend >= CMT_LEN) | ((skid_cnt_nxt == 2'd0) & ring_empty));

   always_ff @(posedge fifoClk) begin
      if (!fifoRstn) begin
         state       <= S_IDLE;
         fetch_ptr   <= '0;
         cons_ptr    <= '0;
         cmt_ptr     <= '0;
         c_rd_ptr    <= '0;
         u_rd_ptr    <= 1'b0;
         skid_cnt    <= 2'd0;
         skid_dat[0] <= '0;
         skid_dat[1] <= '0;
         skid_be[0]  <= '0;
         skid_be[1]  <= '0;
         inflight    <= 1'b0;
         inflight_be <= '0;
      end else begin
         cons_ptr    <= cons_nxt;
         fetch_ptr   <= i_flush ? cons_nxt : fetch_ptr + PW'(ram_rd_en);
         inflight    <= ram_rd_en;
         inflight_be <= be_tag;
         skid_cnt    <= skid_cnt_nxt;

         if (!i_flush) begin
            if (pop) begin
               skid_dat[0] <= skid_dat[1];
               skid_be[0]  <= skid_be[1];
            end
            if (push) begin
               if (cnt_after_pop == 2'd0) begin
                  skid_dat[0] <= ram_rd_data;
                  skid_be[0]  <= inflight_be;
               end else begin
                  skid_dat[1] <= ram_rd_data;
                  skid_be[1]  <= inflight_be;
               end
            end
         end

         u_rd_ptr <= commit;
         if (commit) begin
            c_rd_ptr <= cons_nxt;
            cmt_ptr  <= cons_nxt;
         end

         if (i_flush) begin
            state <= S_FLUSH;
         end else begin
            case (state)
               S_IDLE:  if (!ring_empty) state <= S_FETCH;
               S_FETCH: begin
                  if (skid_cnt == 2'd2 && !out_ready)
                     state <= S_HOLD;
                  else if (ring_empty && !inflight && skid_cnt == 2'd0)
                     state <= S_IDLE;
               end
               S_HOLD:  if (skid_cnt_nxt != 2'd2) state <= S_FETCH;
               S_FLUSH: state <= ring_empty ? S_IDLE : S_FETCH;
            endcase
         end
      end
   end

endmodule
